multicycle_control: RTL

Registered, state-machine control unit for the 8-bit RISC core, replacing single-cycle opcode decoding with a multicycle FETCH/DECODE/EXEC/MEM/WB sequence. It sequences the datapath (IR load, PC update, ALU, data memory, register write-back) and stalls on a valid/ready handshake with instruction and data memory. Opcode and ALU-control widths are parametrised. A retired-instruction counter is included.

---
 rtl/multicycle_control_pkg.sv | 46 ++++
 rtl/multicycle_control_if.sv | 19 +
 rtl/multicycle_control_decode.sv | 57 +++++
 rtl/multicycle_control.sv | 129 ++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle RISC control unit: opcode map, ALU codes,
// the latched control word and the FSM state encoding.
package risc_ctrl_pkg;

    localparam int OP_NOP  = 0;
    localparam int OP_ADD  = 1;
    localparam int OP_SUB  = 2;
    localparam int OP_AND  = 3;
    localparam int OP_OR   = 4;
    localparam int OP_SHL  = 5;
    localparam int OP_SHR  = 6;
    localparam int OP_ADDI = 7;
    localparam int OP_SUBI = 8;
    localparam int OP_LD   = 9;
    localparam int OP_ST   = 10;
    localparam int OP_LDI  = 11;
    localparam int OP_STI  = 12;
    localparam int OP_JMP  = 13;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SHL = 3'b100;
    localparam logic [2:0] ALU_SHR = 3'b101;

    typedef struct packed {
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src;
        logic [2:0] alu_control;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
    } ctrl_word_t;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Instruction/data memory handshake between the control unit (master) and memories (slave).
interface multicycle_control_if;
    logic instr_req;
    logic instr_valid;
    logic ir_write;
    logic mem_read;
    logic mem_write;
    logic mem_ready;

    modport master (
        output instr_req, ir_write, mem_read, mem_write,
        input  instr_valid, mem_ready
    );

    modport slave (
        input  instr_req, ir_write, mem_read, mem_write,
        output instr_valid, mem_ready
    );
endinterface

// File: rtl/multicycle_control_decode.sv
// Combinational opcode decoder: produces the control word and flags undefined opcodes.
module ctrl_decode
    import risc_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4
) (
    input  logic [OPCODE_W-1:0] opcode,
    output ctrl_word_t          word,
    output logic                undefined
);

    logic [31:0] op_val;

    always_comb begin
        word      = '0;
        undefined = 1'b0;
        op_val    = 32'(opcode);
        case (op_val)
            OP_NOP: ;
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                word.reg_write = 1'b1;
                word.reg_dst   = 1'b1;
                case (op_val)
                    OP_ADD:  word.alu_control = ALU_ADD;
                    OP_SUB:  word.alu_control = ALU_SUB;
                    OP_AND:  word.alu_control = ALU_AND;
                    default: word.alu_control = ALU_OR;
                endcase
            end
            OP_SHL, OP_SHR, OP_ADDI, OP_SUBI: begin
                word.reg_write = 1'b1;
                word.alu_src   = 1'b1;
                case (op_val)
                    OP_SHL:  word.alu_control = ALU_SHL;
                    OP_SHR:  word.alu_control = ALU_SHR;
                    OP_ADDI: word.alu_control = ALU_ADD;
                    default: word.alu_control = ALU_SUB;
                endcase
            end
            OP_LD, OP_LDI: begin
                word.reg_write   = 1'b1;
                word.alu_src     = 1'b1;
                word.alu_control = ALU_ADD;
                word.mem_read    = 1'b1;
                word.mem_to_reg  = 1'b1;
            end
            OP_ST, OP_STI: begin
                word.alu_src     = 1'b1;
                word.alu_control = ALU_ADD;
                word.mem_write   = 1'b1;
            end
            OP_JMP: word.branch = 1'b1;
            default: undefined = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB control unit with retired-instruction counter.
// Optional macro ILLEGAL_TRAP_EN: undefined opcodes trap from DECODE instead of running as NOP.
module multicycle_control
    import risc_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int ALUCTL_W = 3,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    multicycle_control_if.master mem,
    output logic                pc_write,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                alu_src,
    output logic                branch,
    output logic                mem_to_reg,
    output logic [ALUCTL_W-1:0] alu_control,
    output logic                busy,
    output logic                illegal_op,
    output logic [CNT_W-1:0]    retired
);

    state_t     state_q, state_d;
    ctrl_word_t ctrl_q;
    ctrl_word_t dec_word;
    logic       dec_undef;
    logic [2:0] alu_code;

    ctrl_decode #(.OPCODE_W(OPCODE_W)) u_decode (
        .opcode    (opcode),
        .word      (dec_word),
        .undefined (dec_undef)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            ctrl_q  <= '0;
            retired <= '0;
        end else begin
            state_q <= state_d;
            // undefined opcodes latch an all-zero word so a non-trapping build retires them as NOP
            if (state_q == S_DECODE) ctrl_q <= dec_undef ? '0 : dec_word;
            if (pc_write) retired <= retired + CNT_W'(1);
        end
    end

    always_comb begin
        state_d       = state_q;
        mem.instr_req = 1'b0;
        mem.ir_write  = 1'b0;
        mem.mem_read  = 1'b0;
        mem.mem_write = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        alu_src       = 1'b0;
        branch        = 1'b0;
        mem_to_reg    = 1'b0;
        alu_code      = 3'b000;
        illegal_op    = 1'b0;
        busy          = (state_q != S_FETCH);
        case (state_q)
            S_FETCH: begin
                mem.instr_req = 1'b1;
                mem.ir_write  = mem.instr_valid;
                if (mem.instr_valid) state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = S_EXEC;
`ifdef ILLEGAL_TRAP_EN
                if (dec_undef) begin
                    illegal_op = 1'b1;
                    pc_write   = 1'b1;
                    state_d    = S_FETCH;
                end
`endif
            end
            S_EXEC: begin
                alu_src    = ctrl_q.alu_src;
                alu_code   = ctrl_q.alu_control;
                reg_dst    = ctrl_q.reg_dst;
                mem_to_reg = ctrl_q.mem_to_reg;
                if (ctrl_q.branch) begin
                    branch   = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_FETCH;
                end else if (ctrl_q.mem_read || ctrl_q.mem_write) begin
                    state_d = S_MEM;
                end else if (ctrl_q.reg_write) begin
                    state_d = S_WB;
                end else begin
                    pc_write = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_MEM: begin
                alu_src       = ctrl_q.alu_src;
                alu_code      = ctrl_q.alu_control;
                reg_dst       = ctrl_q.reg_dst;
                mem_to_reg    = ctrl_q.mem_to_reg;
                mem.mem_read  = ctrl_q.mem_read;
                mem.mem_write = ctrl_q.mem_write;
                if (mem.mem_ready) begin
                    if (ctrl_q.mem_read) begin
                        state_d = S_WB;
                    end else begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                reg_dst    = ctrl_q.reg_dst;
                mem_to_reg = ctrl_q.mem_to_reg;
                alu_code   = ctrl_q.alu_control;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        alu_control = ALUCTL_W'(alu_code);
    end

endmodule
